// File: rtl/convo_frame_sequencer.sv
// Frame sequencer for the XNOR-popcount conv unit: buffers an 8x8 map, walks nine 4x4 patches.
// Macro CONVO_SEQ_PARITY_EN adds an even-parity bit as out_data[6].
module convo_frame_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        w_load,
   input  logic [8:0]  w_data,
   output logic        w_ready,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [15:0] conv_i,
   output logic [15:0] conv_w,
   output logic        conv_sel,
   input  logic [15:0] conv_result,
   output logic        out_valid,
`ifdef CONVO_SEQ_PARITY_EN
   output logic [6:0]  out_data,
`else
   output logic [5:0]  out_data,
`endif
   input  logic        out_ready,
   output logic        frame_done
);

   typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_e;

   state_e      state;
   logic [2:0]  row_cnt;
   logic [3:0]  pcnt;
   logic [2:0]  orow;
   logic [8:0]  kernel;
   logic [7:0]  buffer  [8];
   logic [5:0]  out_map [6];

   logic [3:0]  prev;
   logic [1:0]  cur_pr, cur_pc, prev_pr, prev_pc;
   logic [15:0] patch;
   logic [5:0]  row_out;
   logic        unused_bits;

   function automatic logic [1:0] div3(input logic [3:0] p);
      case (p)
         4'd0, 4'd1, 4'd2: div3 = 2'd0;
         4'd3, 4'd4, 4'd5: div3 = 2'd1;
         4'd6, 4'd7, 4'd8: div3 = 2'd2;
         default:          div3 = 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] mod3(input logic [3:0] p);
      case (p)
         4'd0, 4'd3, 4'd6: mod3 = 2'd0;
         4'd1, 4'd4, 4'd7: mod3 = 2'd1;
         4'd2, 4'd5, 4'd8: mod3 = 2'd2;
         default:          mod3 = 2'd0;
      endcase
   endfunction

   assign unused_bits = ^conv_result[15:4];

   assign in_ready   = (state == StLoad);
   assign w_ready    = (state != StCompute);
   assign out_valid  = (state == StDrain);
   assign conv_w     = {7'b0, kernel};
   assign frame_done = out_valid && out_ready && (orow == 3'd5);

   assign prev    = pcnt - 4'd1;
   assign cur_pr  = div3(pcnt);
   assign cur_pc  = mod3(pcnt);
   assign prev_pr = div3(prev);
   assign prev_pc = mod3(prev);

   // Patch origin is (2*pr, 2*pc); each patch row is a 4-bit window of a buffered row.
   always_comb begin
      logic [2:0] idx;
      logic [7:0] sh;
      patch = '0;
      for (int r = 0; r < 4; r++) begin
         idx = {cur_pr, 1'b0} + 3'(r);
         sh  = buffer[idx] >> {cur_pc, 1'b0};
         patch[r*4 +: 4] = sh[3:0];
      end
   end

   assign row_out = out_valid ? out_map[orow] : 6'h00;
`ifdef CONVO_SEQ_PARITY_EN
   assign out_data = {^row_out, row_out};
`else
   assign out_data = row_out;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= StLoad;
         row_cnt  <= '0;
         pcnt     <= '0;
         orow     <= '0;
         kernel   <= '0;
         conv_i   <= '0;
         conv_sel <= 1'b0;
         for (int i = 0; i < 8; i++) buffer[i] <= '0;
         for (int i = 0; i < 6; i++) out_map[i] <= '0;
      end else begin
         if (w_load && w_ready) kernel <= w_data;
         case (state)
            StLoad: begin
               if (in_valid) begin
                  buffer[row_cnt] <= in_data;
                  row_cnt         <= row_cnt + 3'd1;
                  if (row_cnt == 3'd7) begin
                     state <= StCompute;
                     pcnt  <= '0;
                  end
               end
            end
            StCompute: begin
               // Math unit is combinational: result belongs to the patch registered last edge.
               if (pcnt != 4'd0) begin
                  out_map[{prev_pr, 1'b0}][{prev_pc, 1'b0}] <= conv_result[0];
                  out_map[{prev_pr, 1'b0}][{prev_pc, 1'b1}] <= conv_result[1];
                  out_map[{prev_pr, 1'b1}][{prev_pc, 1'b0}] <= conv_result[2];
                  out_map[{prev_pr, 1'b1}][{prev_pc, 1'b1}] <= conv_result[3];
               end
               if (pcnt < 4'd9) begin
                  conv_i   <= patch;
                  conv_sel <= 1'b1;
                  pcnt     <= pcnt + 4'd1;
               end else begin
                  conv_i   <= '0;
                  conv_sel <= 1'b0;
                  pcnt     <= '0;
                  orow     <= '0;
                  state    <= StDrain;
               end
            end
            StDrain: begin
               if (out_ready) begin
                  if (orow == 3'd5) begin
                     orow    <= '0;
                     row_cnt <= '0;
                     state   <= StLoad;
                  end else begin
                     orow <= orow + 3'd1;
                  end
               end
            end
            default: state <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_convo_frame_sequencer.sv
// Directed, table-driven bench for convo_frame_sequencer with a behavioural XNOR-popcount unit.
module tb_convo_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        w_load = 1'b0;
   logic [8:0]  w_data = '0;
   logic        w_ready;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic [15:0] conv_i;
   logic [15:0] conv_w;
   logic        conv_sel;
   logic [15:0] conv_result;
   logic        out_valid;
`ifdef CONVO_SEQ_PARITY_EN
   logic [6:0]  out_data;
`else
   logic [5:0]  out_data;
`endif
   logic        out_ready = 1'b0;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   convo_frame_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .w_load      (w_load),
      .w_data      (w_data),
      .w_ready     (w_ready),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .conv_i      (conv_i),
      .conv_w      (conv_w),
      .conv_sel    (conv_sel),
      .conv_result (conv_result),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .frame_done  (frame_done)
   );

   // 2x2 sign outputs of a 3x3 XNOR-popcount over a 4x4 patch (+1 when at least 5 of 9 agree).
   function automatic logic [3:0] math(input logic [15:0] p, input logic [15:0] w);
      logic [3:0] res;
      int pop;
      res = '0;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            pop = 0;
            for (int u = 0; u < 3; u++)
               for (int v = 0; v < 3; v++)
                  if (p[(dr + u) * 4 + dc + v] == w[u * 3 + v]) pop++;
            res[dr * 2 + dc] = (pop >= 5);
         end
      return res;
   endfunction

   // Upper bits carry junk the sequencer must ignore.
   always_comb conv_result = {12'hA5A, math(conv_i, conv_w)};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_row(input logic [5:0] e);
`ifdef CONVO_SEQ_PARITY_EN
      return {25'b0, ^e, e};
`else
      return {26'b0, e};
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, " in_ready"},   32'(in_ready),   32'd1);
      chk({tag, " w_ready"},    32'(w_ready),    32'd1);
      chk({tag, " conv_i"},     32'(conv_i),     32'd0);
      chk({tag, " conv_w"},     32'(conv_w),     32'd0);
      chk({tag, " conv_sel"},   32'(conv_sel),   32'd0);
      chk({tag, " out_valid"},  32'(out_valid),  32'd0);
      chk({tag, " out_data"},   32'(out_data),   32'd0);
      chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
   endtask

   task automatic load_frame(input logic [8:0] k, input logic [7:0] re, input logic [7:0] ro);
      @(negedge clk);
      w_load = 1'b1;
      w_data = k;
      chk("w_ready in LOAD", 32'(w_ready), 32'd1);
      @(negedge clk);
      w_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = (i % 2 == 0) ? re : ro;
         if (i == 0 || i == 7) chk($sformatf("in_ready row %0d", i), 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input logic [8:0] k, input logic [7:0] re, input logic [7:0] ro,
                            input logic [5:0] ee, input logic [5:0] eo,
                            input int stall_row, input int stall_n, input int id);
      int cyc, sel_cnt, row, stalls;
      logic rdy;
      load_frame(k, re, ro);
      // Stray input row during COMPUTE must not be taken.
      in_valid = 1'b1;
      in_data  = 8'h3C;
      cyc = 0;
      sel_cnt = 0;
      while (!out_valid && cyc < 20) begin
         if (conv_sel) sel_cnt++;
         if (cyc == 2) chk($sformatf("f%0d in_ready compute", id), 32'(in_ready), 32'd0);
         if (cyc == 3) begin
            in_valid = 1'b0;
            w_load = 1'b1;
            w_data = ~k;
            chk($sformatf("f%0d w_ready compute", id), 32'(w_ready), 32'd0);
         end
         if (cyc == 4) w_load = 1'b0;
         if (cyc == 6) chk($sformatf("f%0d kernel held", id), 32'(conv_w), {23'b0, k});
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("f%0d latency", id), 32'(cyc), 32'd10);
      chk($sformatf("f%0d conv_sel cycles", id), 32'(sel_cnt), 32'd9);
      chk($sformatf("f%0d conv_sel low drain", id), 32'(conv_sel), 32'd0);
      chk($sformatf("f%0d conv_i zero drain", id), 32'(conv_i), 32'd0);
      row = 0;
      stalls = 0;
      cyc = 0;
      while (row < 6 && cyc < 40) begin
         rdy = !(row == stall_row && stalls < stall_n);
         out_ready = rdy;
         #1;
         chk($sformatf("f%0d out_valid r%0d", id, row), 32'(out_valid), 32'd1);
         chk($sformatf("f%0d out_data r%0d", id, row), 32'(out_data),
             exp_row((row % 2 == 0) ? ee : eo));
         chk($sformatf("f%0d frame_done r%0d", id, row), 32'(frame_done),
             32'(rdy && row == 5));
         if (rdy) row++;
         else stalls++;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      chk($sformatf("f%0d rows delivered", id), 32'(row), 32'd6);
      chk($sformatf("f%0d drain cycles", id), 32'(cyc), 32'(6 + ((stall_row >= 0) ? stall_n : 0)));
      chk($sformatf("f%0d in_ready after", id), 32'(in_ready), 32'd1);
      chk($sformatf("f%0d out_valid after", id), 32'(out_valid), 32'd0);
   endtask

   typedef struct {
      logic [8:0] k;
      logic [7:0] re;
      logic [7:0] ro;
      logic [5:0] ee;
      logic [5:0] eo;
      int         stall_row;
      int         stall_n;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{9'h000, 8'h00, 8'h00, 6'h3F, 6'h3F, -1, 0};
      vecs[1] = '{9'h000, 8'hFF, 8'hFF, 6'h00, 6'h00, -1, 0};
      vecs[2] = '{9'h0AA, 8'hAA, 8'h55, 6'h15, 6'h2A, -1, 0};
      vecs[3] = '{9'h1FF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 2, 3};
      vecs[4] = '{9'h155, 8'h00, 8'h00, 6'h00, 6'h00, -1, 0};
      vecs[5] = '{9'h0AA, 8'h00, 8'h00, 6'h3F, 6'h3F, 0, 1};
      vecs[6] = '{9'h1FF, 8'h0F, 8'h0F, 6'h07, 6'h07, 5, 2};
      vecs[7] = '{9'h1FF, 8'hFF, 8'h00, 6'h3F, 6'h00, -1, 0};

      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_frame(vecs[i].k, vecs[i].re, vecs[i].ro, vecs[i].ee, vecs[i].eo,
                   vecs[i].stall_row, vecs[i].stall_n, i);

      // Abort mid-COMPUTE: after the row-7 edge plus 4 more edges pcnt is 4.
      load_frame(9'h1FF, 8'hFF, 8'hFF);
      repeat (4) @(negedge clk);
      chk("abort conv_sel before reset", 32'(conv_sel), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort stays idle", 32'(out_valid), 32'd0);
      run_frame(9'h0AA, 8'hAA, 8'h55, 6'h15, 6'h2A, -1, 0, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
